timer_scheduler: RTL and testbench
==================================

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of software timer channels (fixed range 1..4).
REQ-002 SHALL have parameter CW, default 16, meaning the channel count and period width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, a one-clk timebase pulse (timer timeout event).
REQ-006 SHALL have port address, input, 3, Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 16, write data.
REQ-010 SHALL have port readdata, output, 16, registered read data.
REQ-011 SHALL have port irq, output, 1, the OR of (pending[i] & irq_en[i]) across channels.

Function
REQ-012 SHALL decode the register map as follows: 0 STATUS, 1 CONTROL, 2 CHSEL, 3 PERIOD, 4 COUNT; addresses 5..7 read 0 and ignore writes.
REQ-013 SHALL define STATUS as pending[3:0] in bits 3:0 and overrun in bit 4; writing 1 to a bit clears it, and writing 0 leaves it unchanged.
REQ-014 SHALL define CONTROL as enable[3:0], continuous[7:4] and irq_en[11:8], read/write.
REQ-015 SHALL define CHSEL as bits 1:0 selecting the channel that PERIOD/COUNT access.
REQ-016 SHALL make PERIOD read/write, per channel, CW bits.
REQ-017 SHALL make COUNT read-only and return the live count of the selected channel.
REQ-018 SHALL present readdata one clk after a chipselect read cycle, with zero wait states.
REQ-019 SHALL load count[i] from period[i] on the same write when a CONTROL write takes enable[i] from 0 to 1.
REQ-020 SHALL implement an FSM with states IDLE and SCAN; in IDLE, tick (or a latched tick) moves to SCAN with channel index 0.
REQ-021 SHALL service one channel per clk in SCAN, using one shared decrementer, and return to IDLE after channel NUM_CH-1 (scan length NUM_CH clk).
REQ-022 SHALL, for an enabled channel with nonzero period and count > 1, set count <= count - 1.
REQ-023 SHALL, for an enabled channel with count <= 1, expire it: set pending[i]; if continuous[i] then count <= period[i], else count <= 0 and enable[i] <= 0.
REQ-024 SHALL leave a channel untouched during its scan slot if it is disabled or its period is 0.
REQ-025 SHALL, when tick arrives outside IDLE, latch it in tick_latch and start the next SCAN immediately after the current one.
REQ-026 SHALL, when tick arrives while tick_latch is already set, set overrun and drop the tick.
REQ-027 SHALL let expiry win over a same-cycle STATUS write-1-to-clear: pending stays set.
REQ-028 SHALL let a same-cycle CONTROL write that clears enable[i] override the expiry's enable update; pending is still set.
REQ-029 SHALL have a PERIOD write change only the reload value, not the running count.

Reset
REQ-030 SHALL, on reset assertion, immediately force state=IDLE, tick_latch=0, all pending=0, overrun=0, CONTROL=0, CHSEL=0, all period=0, all count=0, readdata=0 and irq=0.
REQ-031 SHALL, on reset mid-SCAN, abandon the scan with no partial channel update surviving.

Structure
REQ-032 SHALL place the register address constants, the STATUS/CONTROL bit positions and the FSM state type in a shared package timer_scheduler_pkg.
REQ-033 SHALL contain no sub-modules; the channel array and the shared decrementer stay inline.

Verification
REQ-034 Scenario: period0=3, enable0, continuous0, irq_en0 -> pending0 and irq rise during the SCAN of the 3rd tick, and again every 3 ticks thereafter.
REQ-035 Scenario: period1=2, one-shot -> after 2 ticks pending1=1 and enable1 reads 0; further ticks leave count1=0.
REQ-036 Scenario: tick pulses 2 clk apart with NUM_CH=4 -> the 2nd is latched and the 3rd sets STATUS bit 4; writing 0x10 clears it.
REQ-037 Scenario: STATUS write 0x1 in the same clk as channel 0 expiry -> pending0 remains 1.
REQ-038 Scenario: period=0 with enable set -> count unchanged and no pending bit after 10 ticks.
REQ-039 Scenario: reset asserted during SCAN slot 2 -> all registers read 0, and irq=0 in the same cycle.

Source files
------------

// File: rtl/timer_scheduler_pkg.sv
// Shared register map, STATUS/CONTROL field positions and scan FSM state type
// for the timer scheduler.
package timer_scheduler_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_CHSEL   = 3'd2;
    localparam logic [2:0] ADDR_PERIOD  = 3'd3;
    localparam logic [2:0] ADDR_COUNT   = 3'd4;

    localparam int ST_PEND_LSB    = 0;
    localparam int ST_OVERRUN_BIT = 4;

    localparam int CTL_EN_LSB    = 0;
    localparam int CTL_CONT_LSB  = 4;
    localparam int CTL_IRQEN_LSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/timer_scheduler.sv
// Software timer block: up to four channels serviced one per clk by a shared
// decrementer after each timebase tick, with an Avalon-MM register interface.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_CH - 1);

    state_t            state, state_nxt;
    logic [1:0]        scan_idx, scan_idx_nxt;
    logic              tick_latch;
    logic              svc_vld, scan_last;

    logic [NUM_CH-1:0] en, cont, irq_en, pending;
    logic              overrun;
    logic [1:0]        chsel;
    logic [CW-1:0]     period [NUM_CH];
    logic [CW-1:0]     count  [NUM_CH];

    logic              wr, rd;
    logic              wr_status, wr_ctrl, wr_chsel, wr_period;
    logic              chsel_ok;
    logic [NUM_CH-1:0] en_wr, ctl_rise, pend_clr;
    logic [15:0]       rd_mux;

    logic [NUM_CH-1:0] svc_sel, expire_vec, oneshot_clr;
    logic [CW-1:0]     svc_count, svc_period, svc_dec;
    logic              svc_active, svc_expire, overrun_set;

    // ---------------- bus decode ----------------
    assign wr        = chipselect && !write_n;
    assign rd        = chipselect && write_n;
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_ctrl   = wr && (address == ADDR_CONTROL);
    assign wr_chsel  = wr && (address == ADDR_CHSEL);
    assign wr_period = wr && (address == ADDR_PERIOD);
    assign chsel_ok  = int'(chsel) < NUM_CH;

    assign en_wr    = writedata[CTL_EN_LSB +: NUM_CH];
    assign ctl_rise = wr_ctrl ? (en_wr & ~en) : '0;
    assign pend_clr = wr_status ? writedata[ST_PEND_LSB +: NUM_CH] : '0;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            scan_idx <= '0;
        end else begin
            state    <= state_nxt;
            scan_idx <= scan_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        scan_idx_nxt = scan_idx;
        case (state)
            IDLE: begin
                if (tick || tick_latch) begin
                    state_nxt    = SCAN;
                    scan_idx_nxt = '0;
                end
            end
            SCAN: begin
                if (scan_idx == LAST_IDX) begin
                    scan_idx_nxt = '0;
                    state_nxt    = tick_latch ? SCAN : IDLE;
                end else begin
                    scan_idx_nxt = scan_idx + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        svc_vld   = (state == SCAN);
        scan_last = (state == SCAN) && (scan_idx == LAST_IDX);
    end

    // A latched tick is consumed by the back-to-back restart at the last slot;
    // any tick arriving while one is already latched is dropped as overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_latch <= 1'b0;
        end else if (!svc_vld) begin
            tick_latch <= tick && tick_latch;
        end else if (scan_last) begin
            tick_latch <= tick && !tick_latch;
        end else begin
            tick_latch <= tick_latch || tick;
        end
    end

    assign overrun_set = svc_vld && tick && tick_latch;

    // ---------------- shared decrementer ----------------
    always_comb begin
        svc_sel    = '0;
        svc_count  = count[scan_idx];
        svc_period = period[scan_idx];
        svc_dec    = svc_count - CW'(1);
        svc_active = svc_vld && en[scan_idx] && (svc_period != '0);
        svc_expire = svc_active && (svc_count <= CW'(1));
        if (svc_active) svc_sel[scan_idx] = 1'b1;
    end

    assign expire_vec  = svc_expire ? svc_sel : '0;
    assign oneshot_clr = expire_vec & ~cont;

    // ---------------- channel array ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Disabled channels never expire, so a rising enable cannot
                // collide with a scan update of the same channel.
                if (ctl_rise[i]) begin
                    count[i] <= period[i];
                end else if (svc_sel[i]) begin
                    if (svc_expire) count[i] <= cont[i] ? period[i] : '0;
                    else            count[i] <= svc_dec;
                end
                if (wr_period && (int'(chsel) == i)) period[i] <= writedata[CW-1:0];
            end
        end
    end

    // ---------------- control / status registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= '0;
            cont    <= '0;
            irq_en  <= '0;
            pending <= '0;
            overrun <= 1'b0;
            chsel   <= '0;
        end else begin
            // A CPU write decides enable, but a one-shot expiry still clears it.
            en <= (wr_ctrl ? en_wr : en) & ~oneshot_clr;
            if (wr_ctrl) begin
                cont   <= writedata[CTL_CONT_LSB  +: NUM_CH];
                irq_en <= writedata[CTL_IRQEN_LSB +: NUM_CH];
            end
            pending <= (pending & ~pend_clr) | expire_vec;
            overrun <= (overrun && !(wr_status && writedata[ST_OVERRUN_BIT])) || overrun_set;
            if (wr_chsel) chsel <= writedata[1:0];
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[ST_PEND_LSB +: NUM_CH] = pending;
                rd_mux[ST_OVERRUN_BIT]        = overrun;
            end
            ADDR_CONTROL: begin
                rd_mux[CTL_EN_LSB    +: NUM_CH] = en;
                rd_mux[CTL_CONT_LSB  +: NUM_CH] = cont;
                rd_mux[CTL_IRQEN_LSB +: NUM_CH] = irq_en;
            end
            ADDR_CHSEL:  rd_mux[1:0] = chsel;
            ADDR_PERIOD: if (chsel_ok) rd_mux[CW-1:0] = period[chsel];
            ADDR_COUNT:  if (chsel_ok) rd_mux[CW-1:0] = count[chsel];
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   readdata <= '0;
        else if (rd) readdata <= rd_mux;
    end

    assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed scenarios plus a randomized register/tick mix checked against a
// tick-level behavioural model of the timer channels.
module tb_timer_scheduler;

    localparam int NUM_CH = 4;
    localparam int CW     = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Reference model state: one entry per channel, updated once per tick.
    int   m_per  [NUM_CH];
    int   m_cnt  [NUM_CH];
    bit   m_en   [NUM_CH];
    bit   m_cont [NUM_CH];
    bit   m_irqen[NUM_CH];
    bit   m_pend [NUM_CH];
    int   m_chsel;

    timer_scheduler #(.NUM_CH(NUM_CH), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        d = readdata;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Tick pulse followed by enough idle clocks for the whole scan to finish.
    task automatic pulse_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (NUM_CH + 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_per[i] = 0; m_cnt[i] = 0; m_en[i] = 0;
            m_cont[i] = 0; m_irqen[i] = 0; m_pend[i] = 0;
        end
        m_chsel = 0;
    endtask

    // ---------------- model operations ----------------
    task automatic model_tick();
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_en[i] && m_per[i] != 0) begin
                if (m_cnt[i] <= 1) begin
                    m_pend[i] = 1;
                    if (m_cont[i]) m_cnt[i] = m_per[i];
                    else begin m_cnt[i] = 0; m_en[i] = 0; end
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic model_control(input logic [15:0] d);
        for (int i = 0; i < NUM_CH; i++) begin
            if (d[i] && !m_en[i]) m_cnt[i] = m_per[i];
            m_en[i]    = d[i];
            m_cont[i]  = d[4 + i];
            m_irqen[i] = d[8 + i];
        end
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s = '0;
        for (int i = 0; i < NUM_CH; i++) s[i] = m_pend[i];
        return s;
    endfunction

    function automatic logic [15:0] model_ctrl();
        logic [15:0] c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c[i] = m_en[i]; c[4 + i] = m_cont[i]; c[8 + i] = m_irqen[i];
        end
        return c;
    endfunction

    function automatic logic model_irq();
        logic r = 1'b0;
        for (int i = 0; i < NUM_CH; i++) r = r | (m_pend[i] & m_irqen[i]);
        return r;
    endfunction

    initial begin
        logic [15:0] d;
        int op;

        // ---------------- reset state ----------------
        do_reset();
        check("reset_irq", 16'(irq), 16'h0);
        read_check("reset_status",  3'd0, 16'h0000);
        read_check("reset_control", 3'd1, 16'h0000);
        read_check("reset_chsel",   3'd2, 16'h0000);
        read_check("reset_period",  3'd3, 16'h0000);
        read_check("reset_count",   3'd4, 16'h0000);

        // Unmapped addresses read 0 and writes there have no effect.
        bus_write(3'd5, 16'hFFFF);
        read_check("addr5_read", 3'd5, 16'h0000);
        read_check("addr5_no_side_effect", 3'd1, 16'h0000);

        // ---------------- continuous channel 0, period 3 ----------------
        bus_write(3'd3, 16'd3);
        bus_write(3'd1, 16'h0111);
        read_check("c0_count_loaded", 3'd4, 16'd3);
        pulse_tick();
        pulse_tick();
        check("c0_irq_after_2", 16'(irq), 16'h0);
        read_check("c0_count_after_2", 3'd4, 16'd1);
        pulse_tick();
        check("c0_irq_after_3", 16'(irq), 16'h1);
        read_check("c0_status_after_3", 3'd0, 16'h0001);
        read_check("c0_reload_after_3", 3'd4, 16'd3);
        bus_write(3'd0, 16'h0001);
        check("c0_irq_cleared", 16'(irq), 16'h0);
        pulse_tick();
        pulse_tick();
        check("c0_irq_after_5", 16'(irq), 16'h0);
        pulse_tick();
        check("c0_irq_after_6", 16'(irq), 16'h1);

        // ---------------- one-shot channel 1, period 2 ----------------
        do_reset();
        bus_write(3'd2, 16'd1);
        bus_write(3'd3, 16'd2);
        bus_write(3'd1, 16'h0002);
        pulse_tick();
        read_check("os1_status_after_1", 3'd0, 16'h0000);
        pulse_tick();
        read_check("os1_status_after_2", 3'd0, 16'h0002);
        read_check("os1_control_after_2", 3'd1, 16'h0000);
        pulse_tick();
        pulse_tick();
        read_check("os1_count_stays_0", 3'd4, 16'd0);

        // ---------------- tick overrun ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
        repeat (3 * NUM_CH) @(negedge clk);
        read_check("overrun_set", 3'd0, 16'h0010);
        bus_write(3'd0, 16'h0010);
        read_check("overrun_cleared", 3'd0, 16'h0000);

        // ---------------- period 0 and PERIOD write while running ----------------
        do_reset();
        bus_write(3'd2, 16'd2);
        bus_write(3'd3, 16'd5);
        bus_write(3'd1, 16'h0004);
        bus_write(3'd3, 16'd0);
        read_check("p0_count_kept", 3'd4, 16'd5);
        for (int k = 0; k < 10; k++) pulse_tick();
        read_check("p0_count_after_10", 3'd4, 16'd5);
        read_check("p0_no_pending", 3'd0, 16'h0000);

        // ---------------- expiry beats same-cycle W1C ----------------
        do_reset();
        bus_write(3'd3, 16'd1);
        bus_write(3'd1, 16'h0111);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0001;
        @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
        repeat (NUM_CH) @(negedge clk);
        read_check("w1c_vs_expiry", 3'd0, 16'h0001);

        // ---------------- reset in the middle of a scan ----------------
        check("pre_reset_irq", 16'(irq), 16'h1);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midscan_irq", 16'(irq), 16'h0);
        check("midscan_readdata", readdata, 16'h0000);
        @(negedge clk); reset = 1'b0;
        read_check("midscan_status",  3'd0, 16'h0000);
        read_check("midscan_control", 3'd1, 16'h0000);
        read_check("midscan_period",  3'd3, 16'h0000);
        read_check("midscan_count",   3'd4, 16'h0000);

        // ---------------- randomized mix against the model ----------------
        do_reset();
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    m_chsel = int'($urandom_range(0, NUM_CH - 1));
                    bus_write(3'd2, 16'(m_chsel));
                    d = 16'($urandom_range(0, 6));
                    bus_write(3'd3, d);
                    m_per[m_chsel] = int'(d);
                end
                1: begin
                    d = 16'($urandom_range(0, 16'h0FFF));
                    bus_write(3'd1, d);
                    model_control(d);
                end
                2: begin
                    d = 16'($urandom_range(0, 16'h000F));
                    bus_write(3'd0, d);
                    for (int i = 0; i < NUM_CH; i++) if (d[i]) m_pend[i] = 0;
                end
                default: begin
                    pulse_tick();
                    model_tick();
                end
            endcase
            read_check("rnd_status",  3'd0, model_status());
            read_check("rnd_control", 3'd1, model_ctrl());
            read_check("rnd_count",   3'd4, 16'(m_cnt[m_chsel]));
            check("rnd_irq", 16'(irq), 16'(model_irq()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
